// File: rtl/aes_arb_pkg.sv
// Shared types and helpers for the three-requester AES engine arbiter.
// Optional feature macro used by the arbiter top: ARB_TIMEOUT_EN.
package aes_arb_pkg;

   localparam int NREQ  = 3;
   localparam int SEL_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

   // Binary requester index to one-hot grant vector; out-of-range gives zero.
   function automatic logic [NREQ-1:0] onehot3(input logic [SEL_W-1:0] idx);
      logic [NREQ-1:0] oh;
      oh = '0;
      case (idx)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/aes_rr_pick3.sv
// Combinational rotate-priority picker: the first set request found after
// LAST, scanning LAST+1, LAST+2, LAST+3 modulo 3, wins.
module aes_rr_pick3
   import aes_arb_pkg::*;
(
   input  logic [NREQ-1:0]  REQ,
   input  logic [SEL_W-1:0] LAST,
   output logic             VALID,
   output logic [SEL_W-1:0] PICK
);

   assign VALID = |REQ;

   // Walk the circular order starting just after the last winner.
   always_comb begin
      logic found;
      found = 1'b0;
      PICK  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!found && REQ[(int'(LAST) + i) % NREQ]) begin
            PICK  = SEL_W'((int'(LAST) + i) % NREQ);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aes_rr_arb3.sv
// Round-robin arbiter/sequencer for the shared AES-128 round engine.
// Grants one of key-expansion / encrypt / decrypt, pulses START, holds the
// grant until DONE, acknowledges the winner and rotates priority.
// Optional macro ARB_TIMEOUT_EN adds a WAIT watchdog and the ERR output.
module aes_rr_arb3 #(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 7
) (
   input  logic       CLK,
   input  logic       RSTB,
   input  logic [2:0] REQ,
   output logic [2:0] GNT,
   output logic [1:0] SEL,
   output logic       START,
   input  logic       DONE,
   output logic [2:0] ACK,
`ifdef ARB_TIMEOUT_EN
   output logic       ERR,
`endif
   output logic       BUSY
);

   import aes_arb_pkg::*;

   // The watchdog counter must be able to represent TIMEOUT_CYC.
   if ((2 ** CNT_W) <= TIMEOUT_CYC || TIMEOUT_CYC < 1) begin : g_cfg_check
      $error("aes_rr_arb3: CNT_W too narrow for TIMEOUT_CYC");
   end

   arb_state_e       state_q, state_d;
   logic [NREQ-1:0]  gnt_q,   gnt_d;
   logic [SEL_W-1:0] sel_q,   sel_d;
   logic [SEL_W-1:0] last_q,  last_d;
   logic [NREQ-1:0]  ack_q,   ack_d;
   logic             start_q, start_d;
   logic             pick_valid;
   logic [SEL_W-1:0] pick_idx;
`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             err_q,   err_d;
`endif

   aes_rr_pick3 u_pick (
      .REQ   (REQ),
      .LAST  (last_q),
      .VALID (pick_valid),
      .PICK  (pick_idx)
   );

   // Next-state and registered-output logic; ACK/START/ERR default to idle pulses.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      ack_d   = '0;
      start_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         aes_arb_pkg::IDLE: begin
            // DONE is ignored here, so stray completions never produce ACK.
            if (pick_valid) begin
               gnt_d   = onehot3(pick_idx);
               sel_d   = pick_idx;
               start_d = 1'b1;
               state_d = aes_arb_pkg::START;
            end
         end
         aes_arb_pkg::START: begin
            // Engine latency is at least one cycle, so DONE here is stale.
            state_d = aes_arb_pkg::WAIT;
`ifdef ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         aes_arb_pkg::WAIT: begin
            if (DONE) begin
               ack_d   = gnt_q;
               gnt_d   = '0;
               last_d  = sel_q;
               state_d = aes_arb_pkg::IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               // Abort the hung operation and move on in normal rotation.
               err_d   = 1'b1;
               gnt_d   = '0;
               last_d  = sel_q;
               state_d = aes_arb_pkg::IDLE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: begin
            gnt_d   = '0;
            state_d = aes_arb_pkg::IDLE;
         end
      endcase
   end

   // State and output registers; reset leaves requester 0 with top priority.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q <= aes_arb_pkg::IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= 2'd2;
         ack_q   <= '0;
         start_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         ack_q   <= ack_d;
         start_q <= start_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign GNT   = gnt_q;
   assign SEL   = sel_q;
   assign START = start_q;
   assign ACK   = ack_q;
   assign BUSY  = (state_q != aes_arb_pkg::IDLE);
`ifdef ARB_TIMEOUT_EN
   assign ERR   = err_q;
`endif

endmodule

// File: tb/tb_aes_rr_arb3.sv
// Self-checking bench for aes_rr_arb3 (optionally built with ARB_TIMEOUT_EN).
module tb_aes_rr_arb3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] req = 3'b000;
   logic       done = 1'b0;
   logic [2:0] gnt;
   logic [2:0] ack;
   logic [1:0] sel;
   logic       start;
   logic       busy;
`ifdef ARB_TIMEOUT_EN
   logic       err;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int model_last  = 2;   // last requester served, per the reference model

   always #5 clk = ~clk;

   aes_rr_arb3 dut (
      .CLK   (clk),
      .RSTB  (rst_n),
      .REQ   (req),
      .GNT   (gnt),
      .SEL   (sel),
      .START (start),
      .DONE  (done),
      .ACK   (ack),
`ifdef ARB_TIMEOUT_EN
      .ERR   (err),
`endif
      .BUSY  (busy)
   );

   // Reference: among set requests, the one at the smallest circular
   // distance after the last winner (distance 1..3) wins.
   function automatic int model_pick(input logic [2:0] r, input int last);
      int best;
      int best_d;
      int d;
      best   = -1;
      best_d = 4;
      for (int c = 0; c < 3; c++) begin
         if (r[c]) begin
            d = (c - last + 3) % 3;
            if (d == 0) d = 3;
            if (d < best_d) begin
               best_d = d;
               best   = c;
            end
         end
      end
      return best;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 3'b000;
      done  = 1'b0;
      tick();
      rst_n = 1'b1;
      model_last = 2;
   endtask

   // One full grant transaction: request, grant+START, lat WAIT cycles, ACK.
   task automatic do_grant(input logic [2:0] r, input int lat, input bit wobble, input string tag);
      int         exp;
      logic [2:0] exp_oh;
      exp    = model_pick(r, model_last);
      exp_oh = 3'b001 << exp;
      req    = r;
      tick();
      vectors++;
      if (gnt !== exp_oh || start !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s grant: gnt=%b start=%b busy=%b expected gnt=%b start=1 busy=1", tag, gnt, start, busy, exp_oh);
      end
      vectors++;
      if (sel !== exp[1:0]) begin
         miscompares++;
         $display("FAIL %s sel: sel=%0d expected %0d", tag, sel, exp);
      end
      tick();
      vectors++;
      if (start !== 1'b0 || gnt !== exp_oh || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s wait_entry: start=%b gnt=%b busy=%b expected start=0 gnt=%b busy=1", tag, start, gnt, busy, exp_oh);
      end
      for (int k = 1; k < lat; k++) begin
         if (wobble) req = 3'($urandom_range(0, 7));
         tick();
         vectors++;
         if (gnt !== exp_oh || ack !== 3'b000) begin
            miscompares++;
            $display("FAIL %s hold: gnt=%b ack=%b expected gnt=%b ack=000", tag, gnt, ack, exp_oh);
         end
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      vectors++;
      if (ack !== exp_oh || gnt !== 3'b000 || busy !== 1'b0 || sel !== exp[1:0]) begin
         miscompares++;
         $display("FAIL %s ack: ack=%b gnt=%b busy=%b sel=%0d expected ack=%b gnt=000 busy=0 sel=%0d", tag, ack, gnt, busy, sel, exp_oh, exp);
      end
`ifdef ARB_TIMEOUT_EN
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL %s err: err=%b expected 0", tag, err);
      end
`endif
      model_last = exp;
      req = 3'b000;
      $display("grant %s: req=%b -> requester %0d after %0d wait cycles", tag, r, exp, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      vectors++;
      if (gnt !== 3'b000 || sel !== 2'd0 || start !== 1'b0 || ack !== 3'b000 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: gnt=%b sel=%0d start=%b ack=%b busy=%b expected all zero", gnt, sel, start, ack, busy);
      end
`ifdef ARB_TIMEOUT_EN
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_err: err=%b expected 0", err);
      end
`endif
      tick();
      rst_n = 1'b1;
      model_last = 2;
      $display("reset: outputs checked");
   endtask

   task automatic test_idle();
      req = 3'b000;
      for (int k = 0; k < 3; k++) begin
         done = k[0];
         tick();
         vectors++;
         if (busy !== 1'b0 || start !== 1'b0 || ack !== 3'b000 || gnt !== 3'b000) begin
            miscompares++;
            $display("FAIL idle: busy=%b start=%b ack=%b gnt=%b expected all zero", busy, start, ack, gnt);
         end
      end
      done = 1'b0;
      $display("idle: no requests, no activity");
   endtask

   task automatic test_single();
      do_reset();
      do_grant(3'b010, 4, 1'b0, "single");
   endtask

   task automatic test_rotation();
      do_reset();
      for (int k = 0; k < 4; k++) do_grant(3'b111, 3, 1'b0, "rotate");
   endtask

   task automatic test_back_to_back();
      do_reset();
      do_grant(3'b001, 2, 1'b0, "b2b_prime");
      do_grant(3'b101, 2, 1'b0, "b2b_first");
      do_grant(3'b101, 2, 1'b0, "b2b_second");
   endtask

   task automatic test_stray_done();
      logic [2:0] exp_oh;
      int acks;
      do_reset();
      done = 1'b1;
      tick();
      done = 1'b0;
      vectors++;
      if (ack !== 3'b000 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL stray_idle: ack=%b busy=%b expected ack=000 busy=0", ack, busy);
      end
      exp_oh = 3'b001 << model_pick(3'b100, model_last);
      req = 3'b100;
      tick();
      done = 1'b1;       // lands in the START cycle
      tick();
      done = 1'b0;
      vectors++;
      if (ack !== 3'b000 || busy !== 1'b1 || gnt !== exp_oh || start !== 1'b0) begin
         miscompares++;
         $display("FAIL stray_start: ack=%b busy=%b gnt=%b start=%b expected ack=000 busy=1 gnt=%b start=0", ack, busy, gnt, start, exp_oh);
      end
      acks = 0;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      req  = 3'b000;
      if (ack !== 3'b000) acks++;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (ack !== 3'b000) acks++;
      end
      vectors++;
      if (acks != 1) begin
         miscompares++;
         $display("FAIL stray_count: ack pulses=%0d expected 1", acks);
      end
      model_last = 2;
      $display("stray done: ack pulses=%0d", acks);
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      req = 3'b001;
      tick();
      tick();
      tick();            // now in WAIT with GNT=001
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (gnt !== 3'b000 || busy !== 1'b0 || ack !== 3'b000 || start !== 1'b0 || sel !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_wait: gnt=%b busy=%b ack=%b start=%b sel=%0d expected all zero", gnt, busy, ack, start, sel);
      end
      tick();
      vectors++;
      if (ack !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_noack: ack=%b expected 000", ack);
      end
      rst_n = 1'b1;
      model_last = 2;
      $display("reset in wait: grant dropped");
      do_grant(3'b011, 2, 1'b0, "post_reset");
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            req  = 3'b000;
            done = 1'($urandom_range(0, 1));
            tick();
            done = 1'b0;
            vectors++;
            if (busy !== 1'b0 || ack !== 3'b000) begin
               miscompares++;
               $display("FAIL rand_gap: busy=%b ack=%b expected busy=0 ack=000", busy, ack);
            end
         end
         do_grant(3'($urandom_range(1, 7)), int'($urandom_range(1, 5)), 1'b1, "random");
      end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      req = 3'b111;
      tick();
      vectors++;
      if (gnt !== 3'b001 || start !== 1'b1) begin
         miscompares++;
         $display("FAIL to_grant: gnt=%b start=%b expected gnt=001 start=1", gnt, start);
      end
      for (int k = 0; k < 64; k++) begin
         tick();
         vectors++;
         if (gnt !== 3'b001 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_hold: cycle=%0d gnt=%b err=%b expected gnt=001 err=0", k, gnt, err);
         end
      end
      tick();
      vectors++;
      if (err !== 1'b1 || gnt !== 3'b000 || ack !== 3'b000 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL to_abort: err=%b gnt=%b ack=%b busy=%b expected err=1 gnt=000 ack=000 busy=0", err, gnt, ack, busy);
      end
      model_last = 0;
      tick();
      vectors++;
      if (err !== 1'b0 || gnt !== 3'b010 || start !== 1'b1) begin
         miscompares++;
         $display("FAIL to_next: err=%b gnt=%b start=%b expected err=0 gnt=010 start=1", err, gnt, start);
      end
      tick();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      req  = 3'b000;
      model_last = 1;
      $display("timeout: watchdog abort then requester 1 granted");
   endtask
`endif

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_rotation();
      test_back_to_back();
      test_stray_done();
      test_reset_in_wait();
      test_random();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
